// File: rtl/dmem_line_responder.sv
// Memory-side responder for the data-cache line port: one line read or write at a time,
// with a fixed latency and a single-cycle ack.
module dmem_line_responder #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned LATENCY   = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mem_enable_i,
    input  logic                 mem_write_i,
    input  logic [31:0]          mem_addr_i,
    input  logic [LINE_BITS-1:0] mem_data_i,
    output logic                 mem_ack_o,
    output logic [LINE_BITS-1:0] mem_data_o
);

    localparam int unsigned IdxW   = $clog2(DEPTH);
    localparam logic [7:0]  LatCnt = 8'(LATENCY);

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic                   wr_q, wr_d;
    logic [LINE_BITS-1:0]   wdata_q, wdata_d;
    logic                   ack_q, ack_d;
    logic [LINE_BITS-1:0]   rdata_q, rdata_d;
    logic                   mem_we;

    logic [LINE_BITS-1:0]   line_mem [DEPTH];

    // Byte offset and bits above the line index do not select anything.
    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[31:IdxW+5], mem_addr_i[4:0]};

    // cnt counts edges since acceptance; the access happens on the LATENCY-th edge.
    assign mem_we = (state_q == StBusy) && (cnt_q == LatCnt) && wr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (mem_enable_i) begin
                    idx_d   = mem_addr_i[IdxW+4:5];
                    wr_d    = mem_write_i;
                    wdata_d = mem_data_i;
                    cnt_d   = 8'd1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LatCnt) begin
                    state_d = StAck;
                    ack_d   = 1'b1;
                    if (!wr_q) begin
                        rdata_d = line_mem[idx_q];
                    end
                end
            end
            StAck: begin
                cnt_d   = 8'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Line storage is deliberately not reset; reset forces IDLE so no write can slip through.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            line_mem[idx_q] <= wdata_q;
        end
    end

    assign mem_ack_o  = ack_q;
    assign mem_data_o = rdata_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: table of line transactions plus hand-written
// sequences for input churn, reset mid-ack and reset mid-write.
module tb_dmem_line_responder;

    localparam int LAT = 10;

    logic         clk;
    logic         rst;
    logic         en;
    logic         we;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         ack;
    logic [255:0] rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    dmem_line_responder #(
        .LINE_BITS(256),
        .DEPTH    (512),
        .LATENCY  (LAT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_enable_i(en),
        .mem_write_i (we),
        .mem_addr_i  (addr),
        .mem_data_i  (wdata),
        .mem_ack_o   (ack),
        .mem_data_o  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic         hold;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [255:0] pre(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {8{w}};
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Watches the edges after acceptance; reports which edge the ack followed and how many.
    task automatic wait_ack(input logic hold, output int ack_at, output int n,
                            output logic [255:0] d, output int ack_cyc);
        ack_at  = -1;
        n       = 0;
        d       = '0;
        ack_cyc = 0;
        #1;
        if (!hold) en = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                n++;
                if (ack_at < 0) begin
                    ack_at  = k;
                    d       = rdata;
                    ack_cyc = cyc;
                end
                en = 1'b0;
            end
        end
    endtask

    task automatic txn(input string name, input logic wr, input logic [31:0] a,
                       input logic [255:0] dat, input logic hold,
                       output logic [255:0] d, output int ack_cyc);
        int ack_at;
        int n;
        @(negedge clk);
        en    = 1'b1;
        we    = wr;
        addr  = a;
        wdata = dat;
        @(posedge clk);
        wait_ack(hold, ack_at, n, d, ack_cyc);
        chk({name, " ack_edge"}, 256'(ack_at), 256'(LAT));
        chk({name, " ack_count"}, 256'(n), 256'd1);
    endtask

    logic [255:0] d;
    logic [255:0] a5;
    logic [255:0] pat;
    int           ack_at;
    int           n;
    int           c0;
    int           c1;
    int           noack;

    initial begin
        a5  = {32{8'hA5}};
        pat = {4{64'h0123_4567_89AB_CDEF}};
        rst = 1'b1;
        en  = 1'b0;
        we  = 1'b0;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < 8; i++) dut.line_mem[i] = pre(i);
        dut.line_mem[511] = pre(511);
        dut.line_mem[3]   = a5;

        #3;
        chk("reset ack", 256'(ack), 256'd0);
        chk("reset data", rdata, 256'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{wr: 1'b0, addr: 32'h0000_0060, wdata: '0,   hold: 1'b0, exp: a5};
        vecs[1] = '{wr: 1'b1, addr: 32'h4000_0080, wdata: pat, hold: 1'b1, exp: a5};
        vecs[2] = '{wr: 1'b0, addr: 32'h0000_0080, wdata: '1,  hold: 1'b0, exp: pat};
        vecs[3] = '{wr: 1'b0, addr: 32'hFFFF_FFE0, wdata: '0,  hold: 1'b0, exp: pre(511)};
        vecs[4] = '{wr: 1'b0, addr: 32'h0000_0000, wdata: '0,  hold: 1'b0, exp: pre(0)};
        vecs[5] = '{wr: 1'b1, addr: 32'h0000_0020, wdata: pat, hold: 1'b0, exp: pre(0)};

        c0 = 0;
        for (int i = 0; i < 6; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
                d, c1);
            chk($sformatf("vec%0d data", i), d, vecs[i].exp);
            if (i == 2) chk("ack spacing >= 11", 256'(c1 - c0 >= 11), 256'd1);
            c0 = c1;
            @(negedge clk);
            chk($sformatf("vec%0d ack low after", i), 256'(ack), 256'd0);
        end
        chk("line4 written via wrap", dut.line_mem[4], pat);
        chk("line1 written", dut.line_mem[1], pat);

        // Input churn: change everything and drop enable after acceptance.
        dut.line_mem[1] = pre(1);
        @(negedge clk);
        en = 1'b1; we = 1'b1; addr = 32'h20; wdata = pat;
        @(posedge clk);
        #1;
        addr = 32'h40; wdata = '1; we = 1'b0;
        wait_ack(1'b0, ack_at, n, d, c1);
        chk("churn ack_edge", 256'(ack_at), 256'(LAT));
        chk("churn ack_count", 256'(n), 256'd1);
        chk("churn line1", dut.line_mem[1], pat);
        chk("churn line2", dut.line_mem[2], pre(2));
        chk("churn data hold", d, pre(0));

        // Reset asserted mid-cycle during a read's ack cycle.
        @(negedge clk);
        en = 1'b1; we = 1'b0; addr = 32'h60;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("pre-reset ack", 256'(ack), 256'd1);
        chk("pre-reset data", rdata, a5);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset ack", 256'(ack), 256'd0);
        chk("async reset data", rdata, 256'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-write: cnt reaches 5 after the fourth edge following acceptance.
        @(negedge clk);
        en = 1'b1; we = 1'b1; addr = 32'hE0; wdata = '1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        noack = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ack) noack++;
        end
        rst = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (ack) noack++;
        end
        chk("reset-write no ack", 256'(noack), 256'd0);
        chk("reset-write line7", dut.line_mem[7], pre(7));
        txn("post-reset read", 1'b0, 32'hE0, '0, 1'b0, d, c1);
        chk("post-reset read data", d, pre(7));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
